// File: rtl/nes_pad_scan_if.sv
// Pad bus and joypad vector signals for the serial game-pad scanner.
// Names are from the scanner's point of view (i_ = into scanner, o_ = out of scanner).
interface nes_pad_scan_if;
  logic       i_scan_en;
  logic       o_pad_latch;
  logic       o_pad_clk;
  logic       i_pad_data_1p;
  logic       i_pad_data_2p;
  logic [9:0] o_jp_vec_1p;
  logic [9:0] o_jp_vec_2p;
  logic       o_scan_done;

  modport master (
    input  i_scan_en, i_pad_data_1p, i_pad_data_2p,
    output o_pad_latch, o_pad_clk, o_jp_vec_1p, o_jp_vec_2p, o_scan_done
  );

  modport slave (
    output i_scan_en, i_pad_data_1p, i_pad_data_2p,
    input  o_pad_latch, o_pad_clk, o_jp_vec_1p, o_jp_vec_2p, o_scan_done
  );
endinterface

// File: rtl/nes_pad_scan.sv
// Periodic scanner for two SNES-style serial pads: latch, shift 16 bits each,
// debounce across two identical scans and publish 10-bit joypad vectors.
module nes_pad_scan #(
  parameter int unsigned HALF        = 11,
  parameter int unsigned SCAN_PERIOD = 29830
) (
  input  logic           i_clk,
  input  logic           i_rst,
  nes_pad_scan_if.master pad_bus
);
  localparam int unsigned PER_W = $clog2(SCAN_PERIOD);
  localparam int unsigned PH_W  = $clog2(2 * HALF);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SCAN_PERIOD - 1);
  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(2 * HALF - 1);
  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_GAP, S_CLK_LO, S_CLK_HI, S_COMPARE
  } state_t;

  state_t           r_state;
  logic [PER_W-1:0] r_per;
  logic [PH_W-1:0]  r_ph;
  logic [3:0]       r_k;
  logic             r_meta_1p, r_sync_1p, r_meta_2p, r_sync_2p;
  logic [15:0]      r_raw_1p, r_raw_2p, r_prev_1p, r_prev_2p;
  logic [9:0]       r_vec_1p, r_vec_2p;
  logic             r_latch, r_pclk, r_done;

  // Raw bit order is the pad's shift order; vector bits are active-high buttons.
  function automatic logic [9:0] f_map(input logic [15:0] raw);
    return ~{raw[1], raw[9], raw[7], raw[6], raw[5], raw[4], raw[3], raw[2], raw[0], raw[8]};
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_per     <= '0;
      r_ph      <= '0;
      r_k       <= '0;
      r_meta_1p <= 1'b1;
      r_sync_1p <= 1'b1;
      r_meta_2p <= 1'b1;
      r_sync_2p <= 1'b1;
      r_raw_1p  <= '1;
      r_raw_2p  <= '1;
      r_prev_1p <= '1;
      r_prev_2p <= '1;
      r_vec_1p  <= '0;
      r_vec_2p  <= '0;
      r_latch   <= 1'b0;
      r_pclk    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_meta_1p <= pad_bus.i_pad_data_1p;
      r_sync_1p <= r_meta_1p;
      r_meta_2p <= pad_bus.i_pad_data_2p;
      r_sync_2p <= r_meta_2p;
      r_done    <= 1'b0;
      r_per     <= (r_per == PER_LAST) ? '0 : r_per + 1'b1;

      case (r_state)
        S_IDLE: begin
          // Wraps seen outside IDLE are dropped, so a scan never restarts itself.
          if (r_per == PER_LAST && pad_bus.i_scan_en) begin
            r_state <= S_LATCH;
            r_latch <= 1'b1;
            r_ph    <= '0;
          end
        end
        S_LATCH: begin
          if (r_ph == LATCH_LAST) begin
            r_state <= S_GAP;
            r_latch <= 1'b0;
            r_ph    <= '0;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        S_GAP: begin
          if (r_ph == HALF_LAST) begin
            r_raw_1p[0] <= r_sync_1p;
            r_raw_2p[0] <= r_sync_2p;
            r_k         <= 4'd1;
            r_state     <= S_CLK_LO;
            r_pclk      <= 1'b0;
            r_ph        <= '0;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        S_CLK_LO: begin
          if (r_ph == HALF_LAST) begin
            r_state <= S_CLK_HI;
            r_pclk  <= 1'b1;
            r_ph    <= '0;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        S_CLK_HI: begin
          if (r_ph == HALF_LAST) begin
            r_raw_1p[r_k] <= r_sync_1p;
            r_raw_2p[r_k] <= r_sync_2p;
            r_ph          <= '0;
            if (r_k == 4'd15) begin
              r_state <= S_COMPARE;
            end else begin
              r_k     <= r_k + 1'b1;
              r_state <= S_CLK_LO;
              r_pclk  <= 1'b0;
            end
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        S_COMPARE: begin
          if (r_raw_1p == r_prev_1p) r_vec_1p <= f_map(r_raw_1p);
          if (r_raw_2p == r_prev_2p) r_vec_2p <= f_map(r_raw_2p);
          r_prev_1p <= r_raw_1p;
          r_prev_2p <= r_raw_2p;
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pad_bus.o_pad_latch = r_latch;
  assign pad_bus.o_pad_clk   = r_pclk;
  assign pad_bus.o_jp_vec_1p = r_vec_1p;
  assign pad_bus.o_jp_vec_2p = r_vec_2p;
  assign pad_bus.o_scan_done = r_done;
endmodule

// File: tb/tb_nes_pad_scan.sv
// Bench for nes_pad_scan: two behavioural pads plus a scan-level debounce model.
module tb_nes_pad_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rel_cyc = 0;

  // Pad button levels (0 = pressed), snapshot taken when the latch rises.
  logic [15:0] btn1 = '1, btn2 = '1, snap1 = '1, snap2 = '1;
  logic [4:0]  pidx = '0;

  logic [15:0] m_prev1, m_prev2;
  logic [9:0]  m_vec1, m_vec2;
  localparam int SRC [10] = '{8, 0, 2, 3, 4, 5, 6, 7, 9, 1};

  nes_pad_scan_if bus ();

  nes_pad_scan #(.HALF(2), .SCAN_PERIOD(100)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .pad_bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge bus.o_pad_latch or negedge bus.o_pad_clk) begin
    if (bus.o_pad_latch) begin
      snap1 <= btn1;
      snap2 <= btn2;
      pidx  <= '0;
    end else if (!pidx[4]) begin
      pidx <= pidx + 5'd1;
    end
  end

  assign bus.i_pad_data_1p = pidx[4] ? 1'b1 : snap1[pidx[3:0]];
  assign bus.i_pad_data_2p = pidx[4] ? 1'b1 : snap2[pidx[3:0]];

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] ref_map(input logic [15:0] raw);
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[i] = ~raw[SRC[i]];
    return v;
  endfunction

  task automatic model_reset();
    m_prev1 = '1; m_prev2 = '1; m_vec1 = '0; m_vec2 = '0;
  endtask

  task automatic model_scan();
    if (snap1 == m_prev1) m_vec1 = ref_map(snap1);
    if (snap2 == m_prev2) m_vec2 = ref_map(snap2);
    m_prev1 = snap1;
    m_prev2 = snap2;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_scan_done) begin
        got = 1'b1;
        model_scan();
        break;
      end
    end
  endtask

  task automatic wait_latch(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_pad_latch) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_scan_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.o_pad_latch !== 1'b0) begin bad++; $display("FAIL reset_latch got=%b exp=0", bus.o_pad_latch); end
    total++; if (bus.o_pad_clk !== 1'b1) begin bad++; $display("FAIL reset_pclk got=%b exp=1", bus.o_pad_clk); end
    total++; if (bus.o_jp_vec_1p !== 10'h000) begin bad++; $display("FAIL reset_vec1 got=%h exp=000", bus.o_jp_vec_1p); end
    total++; if (bus.o_jp_vec_2p !== 10'h000) begin bad++; $display("FAIL reset_vec2 got=%h exp=000", bus.o_jp_vec_2p); end
    total++; if (bus.o_scan_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.o_scan_done); end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic test_timing();
    bit got;
    int lat0, w, run, pulses, badlen, d1;
    bit sawdone;
    wait_latch(200, got);
    total++; if (!got || cyc - rel_cyc != 100) begin bad++; $display("FAIL first_latch got=%0d exp=100", cyc - rel_cyc); end
    lat0 = cyc;
    w = 0;
    while (bus.o_pad_latch && w < 20) begin w++; @(negedge clk); end
    total++; if (w != 4) begin bad++; $display("FAIL latch_width got=%0d exp=4", w); end
    run = 0; pulses = 0; badlen = 0; sawdone = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.o_pad_clk) run++;
      else begin
        if (run != 0) begin pulses++; if (run != 2) badlen++; end
        run = 0;
      end
      if (bus.o_scan_done) begin sawdone = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!sawdone) begin bad++; $display("FAIL scan1_done got=0 exp=1"); end
    if (sawdone) model_scan();
    total++; if (pulses != 15) begin bad++; $display("FAIL clk_pulses got=%0d exp=15", pulses); end
    total++; if (badlen != 0) begin bad++; $display("FAIL clk_pulse_len got=%0d_bad exp=0_bad", badlen); end
    total++; if (cyc - lat0 != 67) begin bad++; $display("FAIL scan_length got=%0d exp=67", cyc - lat0); end
    d1 = cyc;
    @(negedge clk);
    total++; if (bus.o_scan_done !== 1'b0) begin bad++; $display("FAIL done_width got=%b exp=0", bus.o_scan_done); end
    wait_done(200, got);
    total++; if (!got || cyc - d1 != 100) begin bad++; $display("FAIL done_period got=%0d exp=100", cyc - d1); end
    total++; if (bus.o_jp_vec_1p !== 10'h000 || bus.o_jp_vec_2p !== 10'h000) begin
      bad++; $display("FAIL idle_vecs got=%h/%h exp=000/000", bus.o_jp_vec_1p, bus.o_jp_vec_2p);
    end
  endtask

  task automatic test_debounce_1p();
    bit got;
    btn1 = 16'hFEF7;
    btn2 = '1;
    wait_done(200, got);
    total++; if (!got || bus.o_jp_vec_1p !== 10'h000) begin bad++; $display("FAIL deb_scan1 got=%h exp=000", bus.o_jp_vec_1p); end
    wait_done(200, got);
    total++; if (!got || bus.o_jp_vec_1p !== 10'h009) begin bad++; $display("FAIL deb_scan2_vec1 got=%h exp=009", bus.o_jp_vec_1p); end
    total++; if (bus.o_jp_vec_2p !== 10'h000) begin bad++; $display("FAIL deb_scan2_vec2 got=%h exp=000", bus.o_jp_vec_2p); end
  endtask

  task automatic test_glitch_2p();
    bit got;
    btn2 = 16'hFDFD;
    for (int s = 0; s < 3; s++) begin
      wait_done(200, got);
      btn2 = '1;
      total++; if (!got || bus.o_jp_vec_2p !== 10'h000) begin bad++; $display("FAIL glitch_scan%0d got=%h exp=000", s, bus.o_jp_vec_2p); end
    end
  endtask

  task automatic test_hold_release();
    bit got;
    logic [9:0] exp2 [4] = '{10'h000, 10'h100, 10'h100, 10'h000};
    btn2 = 16'hFDFF;
    for (int s = 0; s < 4; s++) begin
      wait_done(200, got);
      if (s == 1) btn2 = '1;
      total++; if (!got || bus.o_jp_vec_2p !== exp2[s]) begin bad++; $display("FAIL hold_scan%0d got=%h exp=%h", s, bus.o_jp_vec_2p, exp2[s]); end
    end
    total++; if (bus.o_jp_vec_1p !== 10'h009) begin bad++; $display("FAIL hold_vec1 got=%h exp=009", bus.o_jp_vec_1p); end
  endtask

  task automatic test_random();
    bit got;
    int sel;
    for (int s = 0; s < 16; s++) begin
      sel = $urandom_range(4, 0);
      if (sel == 1 || sel == 3) btn1 = 16'($urandom);
      if (sel == 2 || sel == 3) btn2 = 16'($urandom);
      if (sel == 4) btn1 = '1;
      wait_done(200, got);
      total++; if (!got || bus.o_jp_vec_1p !== m_vec1) begin bad++; $display("FAIL rand%0d_vec1 got=%h exp=%h", s, bus.o_jp_vec_1p, m_vec1); end
      total++; if (bus.o_jp_vec_2p !== m_vec2) begin bad++; $display("FAIL rand%0d_vec2 got=%h exp=%h", s, bus.o_jp_vec_2p, m_vec2); end
    end
  endtask

  task automatic test_scan_en_drop();
    bit got, seen, pc_prev;
    int lat0, falls, te;
    wait_latch(200, got);
    lat0 = cyc;
    falls = 0;
    pc_prev = bus.o_pad_clk;
    for (int i = 0; i < 100 && falls < 5; i++) begin
      @(negedge clk);
      if (pc_prev && !bus.o_pad_clk) falls++;
      pc_prev = bus.o_pad_clk;
    end
    bus.i_scan_en = 1'b0;
    total++; if (!got || falls != 5) begin bad++; $display("FAIL en_drop_bit5 got=%0d exp=5", falls); end
    wait_done(100, got);
    total++; if (!got) begin bad++; $display("FAIL en_drop_done got=0 exp=1"); end
    total++; if (bus.o_jp_vec_1p !== m_vec1 || bus.o_jp_vec_2p !== m_vec2) begin
      bad++; $display("FAIL en_drop_vecs got=%h/%h exp=%h/%h", bus.o_jp_vec_1p, bus.o_jp_vec_2p, m_vec1, m_vec2);
    end
    seen = 1'b0;
    repeat (300) begin @(negedge clk); if (bus.o_pad_latch) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL en_off_latch got=1 exp=0"); end
    bus.i_scan_en = 1'b1;
    te = cyc;
    wait_latch(150, got);
    total++; if (!got || (cyc - lat0) % 100 != 0 || cyc - te > 100) begin
      bad++; $display("FAIL en_resume got=%0d exp=multiple_of_100_within_100", cyc - lat0);
    end
    wait_done(100, got);
    total++; if (!got || bus.o_jp_vec_1p !== m_vec1) begin bad++; $display("FAIL en_resume_vec1 got=%h exp=%h", bus.o_jp_vec_1p, m_vec1); end
  endtask

  task automatic test_reset_mid();
    bit got;
    btn1 = 16'hFEF7;
    btn2 = 16'hFDFF;
    wait_done(200, got);
    wait_done(200, got);
    total++; if (!got || bus.o_jp_vec_1p !== 10'h009 || bus.o_jp_vec_2p !== 10'h100) begin
      bad++; $display("FAIL pre_rst_vecs got=%h/%h exp=009/100", bus.o_jp_vec_1p, bus.o_jp_vec_2p);
    end
    wait_latch(200, got);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (!got || bus.o_pad_latch !== 1'b0) begin bad++; $display("FAIL rst_mid_latch got=%b exp=0", bus.o_pad_latch); end
    total++; if (bus.o_pad_clk !== 1'b1) begin bad++; $display("FAIL rst_mid_pclk got=%b exp=1", bus.o_pad_clk); end
    total++; if (bus.o_jp_vec_1p !== 10'h000 || bus.o_jp_vec_2p !== 10'h000) begin
      bad++; $display("FAIL rst_mid_vecs got=%h/%h exp=000/000", bus.o_jp_vec_1p, bus.o_jp_vec_2p);
    end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    rel_cyc = cyc;
    wait_latch(200, got);
    total++; if (!got || cyc - rel_cyc != 100) begin bad++; $display("FAIL rst_relatch got=%0d exp=100", cyc - rel_cyc); end
    wait_done(100, got);
    total++; if (!got || bus.o_jp_vec_1p !== 10'h000) begin bad++; $display("FAIL rst_scan1 got=%h exp=000", bus.o_jp_vec_1p); end
    wait_done(200, got);
    total++; if (!got || bus.o_jp_vec_1p !== 10'h009 || bus.o_jp_vec_2p !== m_vec2) begin
      bad++; $display("FAIL rst_scan2 got=%h/%h exp=009/%h", bus.o_jp_vec_1p, bus.o_jp_vec_2p, m_vec2);
    end
  endtask

  initial begin
    bus.i_scan_en = 1'b0;
    test_reset();
    test_timing();
    test_debounce_1p();
    test_glitch_2p();
    test_hold_release();
    test_random();
    test_scan_en_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
